pipe_csa_adder: RTL and testbench
=================================

Name: pipe_csa_adder

Overview:
- Parametrised, pipelined ripple-segment adder/subtractor for the PipeLine_CSA datapath. Successor to the fixed 2-bit full-adder chain.
- WIDTH-bit operands are split into SEG-bit segments. One segment is resolved per pipeline stage, and the carry is registered between stages.
- Valid/ready handshakes on both sides let it sit between the operand-fetch and writeback stages with backpressure.

Parameters:
- WIDTH, 32, operand/result width in bits; must be an integer multiple of SEG.
- SEG, 8, bits resolved per stage; STAGES = WIDTH/SEG (1 ≤ STAGES ≤ 16).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, operand beat offered.
- in_ready, output, 1, beat accepted when in_valid && in_ready at clk edge.
- a, input, WIDTH, operand A.
- b, input, WIDTH, operand B.
- c_in, input, 1, carry-in; ignored when sub=1.
- sub, input, 1, 0: a+b+c_in; 1: a+~b+1.
- out_valid, output, 1, result beat present.
- out_ready, input, 1, downstream accepts result.
- s, output, WIDTH, sum/difference.
- c_out, output, 1, carry out of MSB (for sub: 1 = no borrow).
- ovf, output, 1, two's-complement signed overflow.

Behaviour:
- Reset (async, any time): all stage valid bits cleared; s, c_out, ovf = 0; out_valid = 0. In-flight beats are discarded, with no partial result emitted. in_ready = 1 while rst is deasserted and the pipe is empty.
- Advance signal: adv = out_ready || !out_valid. in_ready = adv. The whole pipe shifts one stage when adv = 1 and holds all registers when adv = 0. Internal bubbles are not squeezed.
- Stage 0: on acceptance, computes segment 0 = a[SEG-1:0] + b'[SEG-1:0] + cin0, where b' = sub ? ~b : b and cin0 = sub ? 1 : c_in. It registers the segment sum, the carry, and the unresolved upper a/b' bits.
- Stage k (1..STAGES-1): adds segment k of the carried a/b' with the registered carry from stage k-1. It forwards completed lower segments and remaining upper bits unchanged. A stage captures data only when adv = 1; its valid bit copies the previous stage's valid bit (stage 0 copies in_valid && in_ready).
- Output: s, c_out and ovf come from the last-stage registers. ovf = (a[MSB] == b'[MSB]) && (s[MSB] != a[MSB]), evaluated in the last stage with a[MSB] and b'[MSB] carried through.
- Latency: exactly STAGES cycles from acceptance edge to out_valid = 1 when out_ready stays 1. Throughput is one beat per cycle.
- Backpressure: while out_valid && !out_ready, s, c_out, ovf and out_valid hold stable and in_ready = 0. in_valid with in_ready = 0 has no effect.
- Data beats are never reordered, dropped or duplicated.
- STAGES = 1: behaves as a single registered adder with latency 1.
- Wrap-around: results are modulo 2^WIDTH; c_out carries bit WIDTH.
- Outputs are registered only; there are no combinational paths from a/b to s.

Test Plan:
- WIDTH=32, SEG=8, out_ready=1: a=0xFFFFFFFF, b=0x00000001, c_in=0, sub=0 → after 4 cycles s=0x00000000, c_out=1, ovf=0; carry ripples correctly through all segment registers.
- Subtract: a=0x00000005, b=0x00000007, sub=1, c_in=1 (ignored) → s=0xFFFFFFFE, c_out=0, ovf=0. Signed overflow case: a=0x7FFFFFFF, b=0x00000001, sub=0 → s=0x80000000, ovf=1, c_out=0.
- Back-to-back stream: 8 consecutive beats of random a/b with in_valid=1 → 8 consecutive out_valid cycles starting 4 cycles later. Results match a golden model in order.
- Backpressure: drop out_ready for 3 cycles while the pipe is full → in_ready=0 during the stall, outputs held constant, no beat lost. After release, the remaining results emerge in order.
- Reset mid-operation: assert rst asynchronously (between clock edges) with 3 beats in flight → out_valid=0, s=0 immediately. After release, no stale result appears and a new beat produces a correct result after 4 cycles.
- Parameter sweep: WIDTH=16/SEG=16 (latency 1) and WIDTH=16/SEG=2 (latency 8) → exhaustive-random compare against a+b+c_in and a-b, including the edges 0x0000, 0x7FFF, 0x8000 and 0xFFFF.

Source files
------------

// File: rtl/pipe_csa_adder.sv
// Pipelined segmented adder/subtractor. Each stage resolves one SEG-bit
// segment and registers the carry into the next segment. The operand bits
// that are still unresolved travel down the pipe alongside the partial sum.
// The whole pipe advances together under a single valid/ready handshake.
module pipe_csa_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SEG;

  logic             adv_s;
  logic [WIDTH-1:0] bp_s;
  logic             cin_s;

  logic [WIDTH-1:0] s_q;
  logic             c_out_q;
  logic             ovf_q;
  logic             out_valid_q;

  // The pipe moves as a unit whenever the output slot is free or being drained.
  assign adv_s    = out_ready || !out_valid_q;
  assign in_ready = adv_s && !rst;

  // Subtraction is a + ~b + 1, so invert B and force the carry-in.
  assign bp_s  = sub ? ~b : b;
  assign cin_s = sub ? 1'b1 : c_in;

  assign s         = s_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // LO bits are already resolved on entry; REM operand bits remain.
    localparam int LO  = k * SEG;
    localparam int REM = WIDTH - LO;

    logic [REM-1:0]      a_in_s;
    logic [REM-1:0]      bp_in_s;
    logic                cin_in_s;
    logic                vin_s;
    logic [SEG:0]        seg_s;
    logic [LO+SEG-1:0]   res_s;

    if (k == 0) begin : g_src
      assign a_in_s   = a;
      assign bp_in_s  = bp_s;
      assign cin_in_s = cin_s;
      assign vin_s    = in_valid && in_ready;
      assign res_s    = seg_s[SEG-1:0];
    end else begin : g_src
      assign a_in_s   = g_stage[k-1].g_pipe.a_q;
      assign bp_in_s  = g_stage[k-1].g_pipe.bp_q;
      assign cin_in_s = g_stage[k-1].g_pipe.carry_q;
      assign vin_s    = g_stage[k-1].g_pipe.valid_q;
      assign res_s    = {seg_s[SEG-1:0], g_stage[k-1].g_pipe.res_q};
    end

    // Lowest unresolved segment plus the incoming carry; bit SEG is the carry out.
    assign seg_s = {1'b0, a_in_s[SEG-1:0]} + {1'b0, bp_in_s[SEG-1:0]}
                 + {{SEG{1'b0}}, cin_in_s};

    if (k < STAGES - 1) begin : g_pipe
      logic [REM-SEG-1:0] a_q;
      logic [REM-SEG-1:0] bp_q;
      logic [LO+SEG-1:0]  res_q;
      logic               carry_q;
      logic               valid_q;

      // Inter-stage register: partial sum, carry and the still-unresolved operand bits.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q     <= '0;
          bp_q    <= '0;
          res_q   <= '0;
          carry_q <= 1'b0;
          valid_q <= 1'b0;
        end else if (adv_s) begin
          a_q     <= a_in_s[REM-1:SEG];
          bp_q    <= bp_in_s[REM-1:SEG];
          res_q   <= res_s;
          carry_q <= seg_s[SEG];
          valid_q <= vin_s;
        end
      end
    end else begin : g_last
      // Output register: final sum, carry out of the MSB and signed overflow.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s_q         <= '0;
          c_out_q     <= 1'b0;
          ovf_q       <= 1'b0;
          out_valid_q <= 1'b0;
        end else if (adv_s) begin
          s_q         <= res_s;
          c_out_q     <= seg_s[SEG];
          ovf_q       <= (a_in_s[REM-1] == bp_in_s[REM-1]) &&
                         (seg_s[SEG-1] != a_in_s[REM-1]);
          out_valid_q <= vin_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_csa_adder.sv
// Bench for pipe_csa_adder: a 32/8 instance for directed, streaming,
// backpressure and reset checks, plus 16/16 and 16/2 instances for the
// parameter sweep. Results are scored in order against an arithmetic model.
module tb_pipe_csa_adder;

  typedef struct {
    longint a;
    longint b;
    bit     cin;
    bit     sub;
  } beat_t;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out, ovf;
  logic [31:0] a, b, s;

  logic        v16, cin16, sub16, rdy16;
  logic [15:0] a16, b16, sa16, sb16;
  logic        ira, irb, ova, ovb, ca, cb, fa, fb;

  int checks = 0;
  int errors = 0;

  beat_t q32[$];
  beat_t qa[$];
  beat_t qb[$];

  logic [31:0] e32 [4] = '{32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
  logic [15:0] e16 [4] = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_csa_adder #(.WIDTH(32), .SEG(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .c_out(c_out), .ovf(ovf)
  );

  pipe_csa_adder #(.WIDTH(16), .SEG(16)) u_w16s16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(ira),
    .a(a16), .b(b16), .c_in(cin16), .sub(sub16),
    .out_valid(ova), .out_ready(rdy16),
    .s(sa16), .c_out(ca), .ovf(fa)
  );

  pipe_csa_adder #(.WIDTH(16), .SEG(2)) u_w16s2 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(irb),
    .a(a16), .b(b16), .c_in(cin16), .sub(sub16),
    .out_valid(ovb), .out_ready(rdy16),
    .s(sb16), .c_out(cb), .ovf(fb)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic beat_t mk(input longint x, input longint y, input bit ci, input bit sb);
    beat_t t;
    t.a = x; t.b = y; t.cin = ci; t.sub = sb;
    return t;
  endfunction

  // Reference: plain integer arithmetic on w-bit unsigned/signed values.
  task automatic ref_add(input longint x, input longint y, input bit ci, input bit sb,
                         input int w, output longint sum, output bit co, output bit ov);
    longint full, half, sx, sy, sr;
    half = longint'(1) << (w - 1);
    if (sb) begin
      full = x - y;
      co   = (x >= y);
    end else begin
      full = x + y + longint'(ci);
      co   = (full >= 2 * half);
    end
    sum = full & (2 * half - 1);
    sx  = (x >= half) ? x - 2 * half : x;
    sy  = (y >= half) ? y - 2 * half : y;
    sr  = sb ? sx - sy : sx + sy + longint'(ci);
    ov  = (sr >= half) || (sr < -half);
  endtask

  task automatic score(input beat_t bt, input int w, input logic [63:0] gs,
                       input logic gc, input logic go, input string nm);
    longint es;
    bit     ec, eo;
    ref_add(bt.a, bt.b, bt.cin, bt.sub, w, es, ec, eo);
    check({nm, "_s"}, gs, es);
    check({nm, "_cout"}, {63'd0, gc}, {63'd0, ec});
    check({nm, "_ovf"}, {63'd0, go}, {63'd0, eo});
  endtask

  // Scoreboard for the 32-bit instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) q32.push_back(mk(a, b, c_in, sub));
      if (out_valid && out_ready) begin
        if (q32.size() == 0) check("m32_spurious", 64'd1, 64'd0);
        else score(q32.pop_front(), 32, s, c_out, ovf, "m32");
      end
    end
  end

  // Scoreboards for the two 16-bit instances.
  always @(negedge clk) begin
    if (!rst) begin
      if (v16 && ira) qa.push_back(mk(a16, b16, cin16, sub16));
      if (v16 && irb) qb.push_back(mk(a16, b16, cin16, sub16));
      if (ova) begin
        if (qa.size() == 0) check("m16s16_spurious", 64'd1, 64'd0);
        else score(qa.pop_front(), 16, sa16, ca, fa, "m16s16");
      end
      if (ovb) begin
        if (qb.size() == 0) check("m16s2_spurious", 64'd1, 64'd0);
        else score(qb.pop_front(), 16, sb16, cb, fb, "m16s2");
      end
    end
  end

  function automatic logic [31:0] pick32();
    logic [31:0] v;
    if ($urandom_range(3) == 0) v = e32[$urandom_range(3)];
    else v = $urandom;
    return v;
  endfunction

  // Single beat on the 32-bit instance: latency and direct value checks.
  task automatic directed(input logic [31:0] aa, input logic [31:0] bb, input logic ci,
                          input logic sb, input logic [31:0] es, input logic ec, input logic eo);
    int n;
    a = aa; b = bb; c_in = ci; sub = sb; in_valid = 1'b1;
    @(negedge clk);
    check("dir_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("dir_latency", n, 64'd4);
    check("dir_s", {32'd0, s}, {32'd0, es});
    check("dir_cout", {63'd0, c_out}, {63'd0, ec});
    check("dir_ovf", {63'd0, ovf}, {63'd0, eo});
    @(posedge clk); #1;
  endtask

  // Handshake-respecting stream on the 32-bit instance; starts just after a rising edge.
  // mode 0: out_ready high, 1: out_ready low in cycles 6..8, 2: random out_ready.
  task automatic run_cycles(input int nbeats, input int ncyc, input int mode,
                            output logic [31:0] hist);
    int          sent = 0;
    bit          acc = 1'b0;
    bit          stalled = 1'b0;
    logic [31:0] hs;
    logic        hc, ho;
    hist = '0;
    for (int c = 0; c < ncyc; c++) begin
      case (mode)
        1:       out_ready = !(c >= 6 && c <= 8);
        2:       out_ready = ($urandom_range(3) != 0);
        default: out_ready = 1'b1;
      endcase
      if (!in_valid || acc) begin
        if (sent < nbeats) begin
          a = pick32(); b = pick32(); c_in = $urandom_range(1); sub = $urandom_range(1);
          in_valid = 1'b1;
          sent++;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      if (stalled) begin
        check("hold_valid", {63'd0, out_valid}, 64'd1);
        check("hold_s", {32'd0, s}, {32'd0, hs});
        check("hold_cout", {63'd0, c_out}, {63'd0, hc});
        check("hold_ovf", {63'd0, ovf}, {63'd0, ho});
      end
      stalled = out_valid && !out_ready;
      if (stalled) begin
        check("stall_in_ready", {63'd0, in_ready}, 64'd0);
        hs = s; hc = c_out; ho = ovf;
      end
      acc = in_valid && in_ready;
      if (c < 32) hist[c] = out_valid;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
  endtask

  initial begin
    logic [31:0] hist;
    int la, lb;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
    v16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; rdy16 = 1'b1;

    #3;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_s", {32'd0, s}, 64'd0);
    check("rst_cout_ovf", {62'd0, c_out, ovf}, 64'd0);
    check("rst_16_valid", {62'd0, ova, ovb}, 64'd0);
    #20 rst = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready", {63'd0, in_ready}, 64'd1);

    directed(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    directed(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    directed(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);

    run_cycles(8, 20, 0, hist);
    check("stream_hist", {32'd0, hist}, 64'h0000_0FF0);
    check("stream_drained", q32.size(), 64'd0);

    run_cycles(8, 24, 1, hist);
    check("bp_drained", q32.size(), 64'd0);

    run_cycles(40, 90, 2, hist);
    check("rand_drained", q32.size(), 64'd0);

    // Reset with three beats in flight.
    run_cycles(3, 3, 0, hist);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_s", {32'd0, s}, 64'd0);
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
    q32.delete();
    #10 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_stale", {63'd0, out_valid}, 64'd0);
    end
    @(posedge clk); #1;
    directed(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b0, 32'h2222_2221, 1'b0, 1'b0);

    // Parameter sweep: latency of both 16-bit instances, then edges and random.
    a16 = 16'h1234; b16 = 16'h4321; cin16 = 1'b1; sub16 = 1'b0; v16 = 1'b1;
    @(posedge clk); #1;
    v16 = 1'b0;
    la = 0; lb = 0;
    for (int i = 1; i <= 20; i++) begin
      if (ova && la == 0) la = i;
      if (ovb && lb == 0) lb = i;
      @(posedge clk); #1;
    end
    check("lat_w16s16", la, 64'd1);
    check("lat_w16s2", lb, 64'd8);

    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        for (int k = 0; k < 2; k++) begin
          a16 = e16[i]; b16 = e16[j]; sub16 = k[0]; cin16 = $urandom_range(1); v16 = 1'b1;
          @(posedge clk); #1;
        end
      end
    end
    for (int i = 0; i < 60; i++) begin
      a16 = $urandom; b16 = $urandom; sub16 = $urandom_range(1); cin16 = $urandom_range(1);
      v16 = $urandom_range(4) != 0;
      @(posedge clk); #1;
    end
    v16 = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("w16s16_drained", qa.size(), 64'd0);
    check("w16s2_drained", qb.size(), 64'd0);
    check("m32_final_drained", q32.size(), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
